dtcm_lsu_port: RTL

Load/store front-end that sits directly upstream of the 128-bit data TCM. It accepts scalar load/store requests from the backend LSU (byte address, up to 64-bit data), checks alignment and address window, and converts each access into a TCM line index, a 128-bit write lane and a byte mask. It formats the returned TCM line into a sign- or zero-extended 64-bit load result. Throughput is one access per cycle; a response register state supports back-pressure and flush.

---
 rtl/dtcm_lsu_port.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dtcm_lsu_port.sv
// Scalar load/store front-end for the 128-bit data TCM: alignment and window
// checks, byte-lane/mask generation, and load formatting with a response register.
module dtcm_lsu_port #(
  parameter int          AW        = 14,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          TW        = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [63:0]   req_addr,
  input  logic [63:0]   req_wdata,
  input  logic          req_is_store,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [TW-1:0] req_tag,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_rdata,
  output logic [TW-1:0] rsp_tag,
  output logic          rsp_misalign,
  output logic          rsp_fault,
  output logic [AW-1:0] dtcm_addr,
  output logic [127:0]  dtcm_data_dnxt,
  output logic          dtcm_wen,
  output logic [15:0]   dtcm_wmask,
  input  logic [127:0]  dtcm_data_qout,
  output logic          o_dbg_state
);

  // Handshake: a beat transfers on a cycle where valid & ready are both high at
  // the rising CLK edge; neither side may make valid depend on its own ready.
  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t        r_state;
  logic [3:0]    r_off;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [TW-1:0] r_tag;
  logic          r_is_store;
  logic          r_misalign;
  logic          r_fault;
  logic [AW-1:0] r_line;

  logic          w_acc;
  logic          w_misalign;
  logic          w_fault;
  logic          w_wen;
  logic [3:0]    w_off;
  logic [AW-1:0] w_line;
  logic [15:0]   w_bmask;
  logic [63:0]   w_sh;
  logic [63:0]   w_ld;

  // RSTn gating keeps the TCM strobes quiet while reset is held.
  assign req_ready = RSTn & ~flush & ((r_state == IDLE) | rsp_ready);
  assign w_acc     = req_valid & req_ready;
  assign w_off     = req_addr[3:0];
  assign w_line    = req_addr[AW+3:4];
  assign w_fault   = req_addr[63:AW+4] != BASE_ADDR[63:AW+4];

  always_comb begin
    w_misalign = 1'b0;
    w_bmask    = 16'h0001;
    case (req_size)
      2'd0: begin w_misalign = 1'b0;                  w_bmask = 16'h0001; end
      2'd1: begin w_misalign = req_addr[0];           w_bmask = 16'h0003; end
      2'd2: begin w_misalign = |req_addr[1:0];        w_bmask = 16'h000F; end
      default: begin w_misalign = |req_addr[2:0];     w_bmask = 16'h00FF; end
    endcase
  end

  assign w_wen          = w_acc & req_is_store & ~w_misalign & ~w_fault;
  assign dtcm_wen       = w_wen;
  assign dtcm_wmask     = w_wen ? (w_bmask << w_off) : 16'h0000;
  assign dtcm_data_dnxt = {64'h0, req_wdata} << {w_off, 3'b000};
  // Holding the last line keeps dtcm_data_qout stable across a stalled response.
  assign dtcm_addr      = w_acc ? w_line : r_line;

  assign w_sh = 64'(dtcm_data_qout >> {r_off, 3'b000});

  always_comb begin
    w_ld = 64'h0;
    case (r_size)
      2'd0: w_ld = r_unsigned ? {56'h0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
      2'd1: w_ld = r_unsigned ? {48'h0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
      2'd2: w_ld = r_unsigned ? {32'h0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
      default: w_ld = w_sh;
    endcase
  end

  assign rsp_valid    = (r_state == RESP);
  assign rsp_rdata    = (rsp_valid & ~r_is_store & ~r_misalign & ~r_fault) ? w_ld : 64'h0;
  assign rsp_tag      = r_tag;
  assign rsp_misalign = r_misalign;
  assign rsp_fault    = r_fault;
  assign o_dbg_state  = r_state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_off      <= 4'h0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_tag      <= '0;
      r_is_store <= 1'b0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
      r_line     <= '0;
    end else begin
      if (flush) begin
        r_state <= IDLE;
      end else if (w_acc) begin
        r_state    <= RESP;
        r_off      <= w_off;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_tag      <= req_tag;
        r_is_store <= req_is_store;
        r_misalign <= w_misalign;
        r_fault    <= w_fault;
        r_line     <= w_line;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_state <= IDLE;
      end
    end
  end

endmodule
